// File: rtl/ahb_sram_if.sv
// AHB-Lite bundle between the core's master port and the data SRAM.
// No hsel/hresp: the slave is always selected and always answers OKAY.
interface ahb_sram_if;
   logic [31:0] haddr;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;

   modport master (
      output haddr, hsize, htrans, hwrite, hwdata,
      input  hrdata, hready
   );

   modport slave (
      input  haddr, hsize, htrans, hwrite, hwdata,
      output hrdata, hready
   );
endinterface

// File: rtl/ahb_sram.sv
// Word-organised AHB-Lite data SRAM with byte-lane writes, programmable wait states
// and same-edge write-to-read forwarding.
module ahb_sram #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0,
   parameter string       INIT_FILE   = ""
) (
   input logic       clk,
   input logic       rst,
   ahb_sram_if.slave bus
);
   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
   localparam logic [3:0]  W_LAST   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic        HAS_WAIT = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Little-endian lane mask; misaligned halfword/word addresses align down.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] m;
      case (size)
         3'd0:    m = 4'b0001 << lo;
         3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   logic [31:0]   mem [DEPTH];

   state_t        state_r;
   logic [3:0]    wcnt_r;
   logic          pend_valid_r;
   logic          pend_write_r;
   logic          pend_inr_r;
   logic [AW-1:0] pend_idx_r;
   logic [3:0]    pend_be_r;
   logic          hready_r;
   logic [31:0]   hrdata_r;

   logic [32:0]   off_s;
   logic          addr_inr_s;
   logic [AW-1:0] addr_idx_s;
   logic          capture_s;
   logic          wr_en_s;
   logic          rd_en_s;
   logic          rd_inr_s;
   logic [AW-1:0] rd_idx_s;
   logic [31:0]   rd_word_s;

   // Decode the address phase on the bus and select the read source, forwarding the committing write.
   always_comb begin
      // A borrow sets off_s[32], which keeps addresses below BASE_ADDR out of range.
      off_s      = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
      addr_inr_s = (off_s < SPAN);
      addr_idx_s = off_s[AW+1:2];
      capture_s  = hready_r & bus.htrans[1];
      wr_en_s    = ~rst & (state_r == ST_DATA) & pend_valid_r & pend_write_r & pend_inr_r;
      if (state_r == ST_WAIT) begin
         rd_en_s  = (wcnt_r == W_LAST) & ~pend_write_r;
         rd_inr_s = pend_inr_r;
         rd_idx_s = pend_idx_r;
      end else begin
         rd_en_s  = capture_s & ~HAS_WAIT & ~bus.hwrite;
         rd_inr_s = addr_inr_s;
         rd_idx_s = addr_idx_s;
      end
      rd_word_s = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         if (!rd_inr_s) begin
            rd_word_s[8*i +: 8] = 8'h00;
         end else if (wr_en_s && (pend_idx_r == rd_idx_s) && pend_be_r[i]) begin
            rd_word_s[8*i +: 8] = bus.hwdata[8*i +: 8];
         end else begin
            rd_word_s[8*i +: 8] = mem[rd_idx_s][8*i +: 8];
         end
      end
   end

   // Transfer sequencing: address capture, wait-state counting, registered hready/hrdata.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         wcnt_r       <= 4'd0;
         pend_valid_r <= 1'b0;
         pend_write_r <= 1'b0;
         pend_inr_r   <= 1'b0;
         pend_idx_r   <= '0;
         pend_be_r    <= 4'b0000;
         hready_r     <= 1'b1;
         hrdata_r     <= 32'h0000_0000;
      end else begin
         if (rd_en_s) begin
            hrdata_r <= rd_word_s;
         end
         if (capture_s) begin
            pend_valid_r <= 1'b1;
            pend_write_r <= bus.hwrite;
            pend_inr_r   <= addr_inr_s;
            pend_idx_r   <= addr_idx_s;
            pend_be_r    <= lane_mask(bus.hsize, bus.haddr[1:0]);
         end else if (hready_r) begin
            pend_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE, ST_DATA: begin
               wcnt_r <= 4'd0;
               if (capture_s && HAS_WAIT) begin
                  state_r  <= ST_WAIT;
                  hready_r <= 1'b0;
               end else if (capture_s) begin
                  state_r  <= ST_DATA;
                  hready_r <= 1'b1;
               end else begin
                  state_r  <= ST_IDLE;
                  hready_r <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (wcnt_r == W_LAST) begin
                  state_r  <= ST_DATA;
                  hready_r <= 1'b1;
                  wcnt_r   <= 4'd0;
               end else begin
                  wcnt_r   <= wcnt_r + 4'd1;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               hready_r <= 1'b1;
               wcnt_r   <= 4'd0;
            end
         endcase
      end
   end

   // RAM write port with byte-lane enables; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int i = 0; i < 4; i++) begin
            if (pend_be_r[i]) begin
               mem[pend_idx_r][8*i +: 8] <= bus.hwdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.hready = hready_r;
   assign bus.hrdata = hrdata_r;
endmodule
